// File: rtl/swan_bus_master.sv
// swan_bus_master: sequences one cartridge bus cycle per accepted request
// through SETUP, STROBE and HOLD phases with programmable lengths.
// Optional feature macro: SWAN_BUS_MASTER_IO_EN (honour ReqIo on nIO).
// Without it every cycle is a memory cycle and nIO stays high.
module swan_bus_master #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 2
) (
  input  logic        FastClk,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic        ReqIo,
  input  logic [8:0]  ReqAddrLo,
  input  logic [3:0]  ReqAddrHi,
  input  logic [15:0] ReqData,
  output logic        RespValid,
  output logic [15:0] RdData,
  output logic        nSel,
  output logic        nOE,
  output logic        nWE,
  output logic        nIO,
  output logic [8:0]  AddrLo,
  output logic [3:0]  AddrHi,
  output logic [15:0] DataOut,
  output logic        DataOe,
  input  logic [15:0] DataIn
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} busStateT;

`ifdef SWAN_BUS_MASTER_IO_EN
  localparam bit IoEnable = 1'b1;
`else
  localparam bit IoEnable = 1'b0;
`endif

  localparam logic [3:0] SetupLast  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] StrobeLast = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HoldLast   = 4'(HOLD_CYCLES - 1);

  busStateT    state;
  busStateT    nextState;
  logic [3:0]  phase;
  logic [3:0]  nextPhase;
  logic        running;
  logic        writeR;
  logic        ioR;
  logic        accept;
  logic        nextWrite;
  logic        nextIo;
  logic        nextActive;
  logic        nextStrobe;
  logic        lastStrobe;

  // ReqReady is held low during reset and for the edge that releases it
  assign ReqReady = (state == IDLE) && running;
  assign accept   = ReqValid && ReqReady;

  // Next-state and phase counter decode; also precompute next-cycle pin values
  always_comb begin
    nextState  = state;
    nextPhase  = phase;
    nextWrite  = writeR;
    nextIo     = ioR;
    lastStrobe = 1'b0;
    if (accept) begin
      nextWrite = ReqWrite;
      nextIo    = ReqIo;
    end
    case (state)
      IDLE: begin
        if (accept) begin
          nextState = SETUP;
          nextPhase = 4'd0;
        end
      end
      SETUP: begin
        if (phase == SetupLast) begin
          nextState = STROBE;
          nextPhase = 4'd0;
        end else begin
          nextPhase = phase + 4'd1;
        end
      end
      STROBE: begin
        if (phase == StrobeLast) begin
          nextState  = HOLD;
          nextPhase  = 4'd0;
          lastStrobe = 1'b1;
        end else begin
          nextPhase = phase + 4'd1;
        end
      end
      HOLD: begin
        if (phase == HoldLast) begin
          nextState = IDLE;
          nextPhase = 4'd0;
        end else begin
          nextPhase = phase + 4'd1;
        end
      end
      default: begin
        nextState = IDLE;
        nextPhase = 4'd0;
      end
    endcase
    nextActive = (nextState != IDLE);
    nextStrobe = (nextState == STROBE);
  end

  // State register and shared phase counter
  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      phase   <= 4'd0;
      running <= 1'b0;
    end else begin
      state   <= nextState;
      phase   <= nextPhase;
      running <= 1'b1;
    end
  end

  // Capture the request fields on acceptance; they double as the address/data pins
  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) begin
      writeR  <= 1'b0;
      ioR     <= 1'b0;
      AddrLo  <= '0;
      AddrHi  <= '0;
      DataOut <= '0;
    end else if (accept) begin
      writeR  <= ReqWrite;
      ioR     <= ReqIo;
      AddrLo  <= ReqAddrLo;
      AddrHi  <= ReqAddrHi;
      DataOut <= ReqData;
    end
  end

  // Registered bus controls, derived from the state being entered
  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) begin
      nSel   <= 1'b1;
      nOE    <= 1'b1;
      nWE    <= 1'b1;
      nIO    <= 1'b1;
      DataOe <= 1'b0;
    end else begin
      nSel   <= !nextActive;
      nOE    <= !(nextStrobe && !nextWrite);
      nWE    <= !(nextStrobe && nextWrite);
      nIO    <= !(nextActive && nextIo && IoEnable);
      DataOe <= nextActive && nextWrite;
    end
  end

  // Read data is taken on the final strobe edge and flagged for one HOLD cycle
  always_ff @(posedge FastClk or posedge Reset) begin
    if (Reset) begin
      RespValid <= 1'b0;
      RdData    <= '0;
    end else begin
      RespValid <= lastStrobe && !writeR;
      if (lastStrobe && !writeR) begin
        RdData <= DataIn;
      end
    end
  end

endmodule

// File: tb/tb_swan_bus_master.sv
// tb_swan_bus_master: randomized and directed checks of swan_bus_master
// against a cycle-offset reference model; a second instance uses 1/1/1 timing.
module tb_swan_bus_master;

  typedef struct packed {
    logic        wr;
    logic        io;
    logic [8:0]  lo;
    logic [3:0]  hi;
    logic [15:0] d;
  } txnT;

`ifdef SWAN_BUS_MASTER_IO_EN
  localparam bit IoEn = 1'b1;
`else
  localparam bit IoEn = 1'b0;
`endif

  logic        FastClk = 1'b0;
  logic        Reset = 1'b1;
  logic        ReqValid = 1'b0;
  logic        ReqValidF = 1'b0;
  logic        ReqWrite = 1'b0;
  logic        ReqIo = 1'b0;
  logic [8:0]  ReqAddrLo = '0;
  logic [3:0]  ReqAddrHi = '0;
  logic [15:0] ReqData = '0;
  logic [15:0] DataIn = '0;

  logic        readyA, respA, nSelA, nOEA, nWEA, nIOA, oeA;
  logic [15:0] rdA, doutA;
  logic [8:0]  loA;
  logic [3:0]  hiA;
  logic        readyB, respB, nSelB, nOEB, nWEB, nIOB, oeB;
  logic [15:0] rdB, doutB;
  logic [8:0]  loB;
  logic [3:0]  hiB;

  bit          useFast = 1'b0;
  logic        obsReady, obsResp, obsNSel, obsNOE, obsNWE, obsNIO, obsOe;
  logic [15:0] obsRd, obsDout;
  logic [8:0]  obsLo;
  logic [3:0]  obsHi;

  int          checks = 0;
  int          fails = 0;
  logic [15:0] rdModel [2];

  swan_bus_master dut (
    .FastClk(FastClk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(readyA),
    .ReqWrite(ReqWrite), .ReqIo(ReqIo), .ReqAddrLo(ReqAddrLo), .ReqAddrHi(ReqAddrHi),
    .ReqData(ReqData), .RespValid(respA), .RdData(rdA), .nSel(nSelA), .nOE(nOEA),
    .nWE(nWEA), .nIO(nIOA), .AddrLo(loA), .AddrHi(hiA), .DataOut(doutA),
    .DataOe(oeA), .DataIn(DataIn)
  );

  swan_bus_master #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) dutFast (
    .FastClk(FastClk), .Reset(Reset), .ReqValid(ReqValidF), .ReqReady(readyB),
    .ReqWrite(ReqWrite), .ReqIo(ReqIo), .ReqAddrLo(ReqAddrLo), .ReqAddrHi(ReqAddrHi),
    .ReqData(ReqData), .RespValid(respB), .RdData(rdB), .nSel(nSelB), .nOE(nOEB),
    .nWE(nWEB), .nIO(nIOB), .AddrLo(loB), .AddrHi(hiB), .DataOut(doutB),
    .DataOe(oeB), .DataIn(DataIn)
  );

  always #5 FastClk = ~FastClk;

  assign obsReady = useFast ? readyB : readyA;
  assign obsResp  = useFast ? respB  : respA;
  assign obsNSel  = useFast ? nSelB  : nSelA;
  assign obsNOE   = useFast ? nOEB   : nOEA;
  assign obsNWE   = useFast ? nWEB   : nWEA;
  assign obsNIO   = useFast ? nIOB   : nIOA;
  assign obsOe    = useFast ? oeB    : oeA;
  assign obsRd    = useFast ? rdB    : rdA;
  assign obsDout  = useFast ? doutB  : doutA;
  assign obsLo    = useFast ? loB    : loA;
  assign obsHi    = useFast ? hiB    : hiA;

  function automatic txnT randTxn();
    txnT t;
    t.wr = 1'($urandom_range(0, 1));
    t.io = 1'($urandom_range(0, 1));
    t.lo = 9'($urandom);
    t.hi = 4'($urandom);
    t.d  = 16'($urandom);
    return t;
  endfunction

  function automatic txnT mkTxn(input logic wr, input logic io, input logic [8:0] lo,
                                input logic [3:0] hi, input logic [15:0] d);
    txnT t;
    t.wr = wr; t.io = io; t.lo = lo; t.hi = hi; t.d = d;
    return t;
  endfunction

  task automatic present(input bit fast, input txnT t);
    ReqWrite  = t.wr;
    ReqIo     = t.io;
    ReqAddrLo = t.lo;
    ReqAddrHi = t.hi;
    ReqData   = t.d;
    if (fast) ReqValidF = 1'b1;
    else ReqValid = 1'b1;
  endtask

  // One bus cycle: accept, then check every pin per cycle offset from acceptance
  task automatic runTxn(input bit fast, input txnT t, input bit chain, input txnT nxt,
                        input bit fixDin, input logic [15:0] dinVal);
    int s, st, h, total;
    bit gotReady;
    logic [15:0] captured;
    logic active, strobe, respNow;
    logic expNSel, expNOE, expNWE, expNIO, expOe, expReady;
    useFast  = fast;
    s        = fast ? 1 : 2;
    st       = fast ? 1 : 4;
    h        = fast ? 1 : 2;
    total    = s + st + h;
    captured = '0;
    present(fast, t);
    gotReady = 1'b0;
    for (int w = 0; w < 30; w++) begin
      if (obsReady === 1'b1) begin
        gotReady = 1'b1;
        break;
      end
      @(negedge FastClk);
    end
    checks++;
    if (!gotReady) begin
      fails++;
      $display("[TB] FAIL acceptWait: ReqReady got %b required 1 within 30 cycles", obsReady);
      ReqValid = 1'b0;
      ReqValidF = 1'b0;
      return;
    end
    @(posedge FastClk);
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge FastClk);
      if (k == 1) begin
        if (chain) present(fast, nxt);
        else begin
          ReqValid = 1'b0;
          ReqValidF = 1'b0;
          present(fast, randTxn());
          ReqValid = 1'b0;
          ReqValidF = 1'b0;
        end
      end
      active   = (k <= total);
      strobe   = (k > s) && (k <= s + st);
      respNow  = !t.wr && (k == s + st + 1);
      if (respNow) rdModel[fast] = captured;
      expNSel  = !active;
      expNOE   = !(strobe && !t.wr);
      expNWE   = !(strobe && t.wr);
      expNIO   = IoEn ? !(active && t.io) : 1'b1;
      expOe    = active && t.wr;
      expReady = (k == total + 1);
      checks++;
      if (obsNSel !== expNSel) begin
        fails++;
        $display("[TB] FAIL nSel k=%0d: got %b required %b", k, obsNSel, expNSel);
      end
      checks++;
      if (obsNOE !== expNOE) begin
        fails++;
        $display("[TB] FAIL nOE k=%0d: got %b required %b", k, obsNOE, expNOE);
      end
      checks++;
      if (obsNWE !== expNWE) begin
        fails++;
        $display("[TB] FAIL nWE k=%0d: got %b required %b", k, obsNWE, expNWE);
      end
      checks++;
      if (obsNIO !== expNIO) begin
        fails++;
        $display("[TB] FAIL nIO k=%0d: got %b required %b", k, obsNIO, expNIO);
      end
      checks++;
      if (obsOe !== expOe) begin
        fails++;
        $display("[TB] FAIL DataOe k=%0d: got %b required %b", k, obsOe, expOe);
      end
      checks++;
      if (obsReady !== expReady) begin
        fails++;
        $display("[TB] FAIL ReqReady k=%0d: got %b required %b", k, obsReady, expReady);
      end
      checks++;
      if (obsResp !== respNow) begin
        fails++;
        $display("[TB] FAIL RespValid k=%0d: got %b required %b", k, obsResp, respNow);
      end
      checks++;
      if (obsRd !== rdModel[fast]) begin
        fails++;
        $display("[TB] FAIL RdData k=%0d: got %h required %h", k, obsRd, rdModel[fast]);
      end
      checks++;
      if (obsLo !== t.lo || obsHi !== t.hi) begin
        fails++;
        $display("[TB] FAIL addr k=%0d: got %h/%h required %h/%h", k, obsHi, obsLo, t.hi, t.lo);
      end
      if (active && t.wr) begin
        checks++;
        if (obsDout !== t.d) begin
          fails++;
          $display("[TB] FAIL DataOut k=%0d: got %h required %h", k, obsDout, t.d);
        end
      end
      DataIn = fixDin ? dinVal : 16'($urandom);
      if (k == s + st) captured = DataIn;
    end
  endtask

  // Reset values on both instances, then ReqReady one edge after release
  task automatic test_reset();
    useFast = 1'b0;
    repeat (3) @(negedge FastClk);
    checks++;
    if ({nSelA, nOEA, nWEA, nIOA, oeA, respA, readyA, readyB} !== 8'b1111_0000) begin
      fails++;
      $display("[TB] FAIL resetCtl: got %b required 11110000",
               {nSelA, nOEA, nWEA, nIOA, oeA, respA, readyA, readyB});
    end
    checks++;
    if ({loA, hiA, doutA, rdA} !== 45'd0) begin
      fails++;
      $display("[TB] FAIL resetData: got %h required 0", {loA, hiA, doutA, rdA});
    end
    Reset = 1'b0;
    #1;
    checks++;
    if (readyA !== 1'b0) begin
      fails++;
      $display("[TB] FAIL readyBeforeEdge: got %b required 0", readyA);
    end
    @(negedge FastClk);
    checks++;
    if (readyA !== 1'b1 || readyB !== 1'b1) begin
      fails++;
      $display("[TB] FAIL readyAfterRelease: got %b%b required 11", readyA, readyB);
    end
  endtask

  task automatic test_memory_read();
    runTxn(1'b0, mkTxn(1'b0, 1'b0, 9'h0F0, 4'hF, 16'h1234), 1'b0, randTxn(), 1'b1, 16'hA55A);
    checks++;
    if (rdModel[0] !== 16'hA55A) begin
      fails++;
      $display("[TB] FAIL readModel: got %h required a55a", rdModel[0]);
    end
  endtask

  task automatic test_io_write();
    runTxn(1'b0, mkTxn(1'b1, 1'b1, 9'h001, 4'hE, 16'h0002), 1'b0, randTxn(), 1'b0, 16'h0);
  endtask

  task automatic test_io_read();
    runTxn(1'b0, mkTxn(1'b0, 1'b1, 9'h0F0, 4'hF, 16'h0000), 1'b0, randTxn(), 1'b1, 16'h5AA5);
  endtask

  task automatic test_back_to_back();
    txnT a, b;
    a = mkTxn(1'b0, 1'b0, 9'h011, 4'h3, 16'h0);
    b = mkTxn(1'b0, 1'b1, 9'h122, 4'h4, 16'h0);
    runTxn(1'b0, a, 1'b1, b, 1'b0, 16'h0);
    runTxn(1'b0, b, 1'b0, randTxn(), 1'b0, 16'h0);
  endtask

  task automatic test_fast_params();
    runTxn(1'b1, mkTxn(1'b0, 1'b0, 9'h1AB, 4'h7, 16'h0), 1'b0, randTxn(), 1'b1, 16'hC3C3);
    runTxn(1'b1, mkTxn(1'b1, 1'b0, 9'h055, 4'h2, 16'hBEEF), 1'b0, randTxn(), 1'b0, 16'h0);
  endtask

  task automatic test_random();
    txnT cur, nxt;
    bit chain;
    for (int inst = 0; inst < 2; inst++) begin
      cur = randTxn();
      for (int i = 0; i < 8; i++) begin
        nxt = randTxn();
        chain = (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
        runTxn(inst[0], cur, chain, nxt, 1'b0, 16'h0);
        cur = nxt;
      end
    end
  endtask

  // Reset mid-STROBE of a write must drop the strobe asynchronously
  task automatic test_reset_abort();
    useFast = 1'b0;
    present(1'b0, mkTxn(1'b1, 1'b0, 9'h0AA, 4'h9, 16'h7777));
    for (int w = 0; w < 30 && readyA !== 1'b1; w++) @(negedge FastClk);
    @(posedge FastClk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge FastClk);
      if (k == 1) ReqValid = 1'b0;
    end
    checks++;
    if (nWEA !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abortPre nWE: got %b required 0", nWEA);
    end
    #1 Reset = 1'b1;
    #1;
    checks++;
    if ({nWEA, nSelA, oeA, respA, readyA} !== 5'b11000) begin
      fails++;
      $display("[TB] FAIL abortAsync: got %b required 11000", {nWEA, nSelA, oeA, respA, readyA});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge FastClk);
      checks++;
      if (respA !== 1'b0 || nSelA !== 1'b1) begin
        fails++;
        $display("[TB] FAIL abortHold c=%0d: got resp %b nSel %b required 0 1", c, respA, nSelA);
      end
    end
    Reset = 1'b0;
    rdModel[0] = '0;
    rdModel[1] = '0;
    @(negedge FastClk);
    checks++;
    if (readyA !== 1'b1 || nSelA !== 1'b1 || respA !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abortRelease: got ready %b nSel %b resp %b required 1 1 0",
               readyA, nSelA, respA);
    end
    runTxn(1'b0, mkTxn(1'b0, 1'b0, 9'h1FF, 4'h1, 16'h0), 1'b0, randTxn(), 1'b0, 16'h0);
  endtask

  initial begin
    rdModel[0] = '0;
    rdModel[1] = '0;
    test_reset();
    test_memory_read();
    test_io_write();
    test_io_read();
    test_back_to_back();
    test_fast_params();
    test_random();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/swan_bus_master.md
SWAN_BUS_MASTER -- requirements
Module: swan_bus_master

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 2, FastClk cycles the address/nIO/write data are driven before the strobe (range 1..15).
REQ-002 SHALL have parameter STROBE_CYCLES, default 4, FastClk cycles nOE or nWE is held low (range 1..15).
REQ-003 SHALL have parameter HOLD_CYCLES, default 2, FastClk cycles the address/data are held after the strobe rises (range 1..15).
REQ-004 SHALL have port FastClk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports ReqValid input 1, ReqReady output 1: request handshake; a request transfers on a cycle where both are high.
REQ-007 SHALL have ports ReqWrite input 1 (1=write, 0=read), ReqIo input 1 (1=I/O cycle, 0=memory cycle).
REQ-008 SHALL have ports ReqAddrLo input 9, ReqAddrHi input 4, ReqData input 16: request address and write data.
REQ-009 SHALL have ports RespValid output 1, RdData output 16: one-cycle read-completion pulse with captured data.
REQ-010 SHALL have ports nSel, nOE, nWE, nIO  output  1 each: active-low cartridge bus controls.
REQ-011 SHALL have ports AddrLo output 9, AddrHi output 4: cartridge bus address.
REQ-012 SHALL have ports DataOut output 16, DataOe output 1, DataIn input 16: split cartridge data bus; the pad tristate is outside this block.

Function
REQ-013 SHALL implement states IDLE, SETUP, STROBE, HOLD with one shared 4-bit phase counter.
REQ-014 SHALL drive ReqReady high only in IDLE; requests presented in other states SHALL be stalled, not dropped.
REQ-015 SHALL, on transfer in IDLE, register all Req* fields and enter SETUP on the next cycle; registered fields SHALL stay stable until IDLE is re-entered.
REQ-016 SHALL, in SETUP, HOLD and STROBE, drive nSel low, AddrLo/AddrHi from registered address, nIO low when registered ReqIo=1; in IDLE nSel=nIO=1 and AddrLo/AddrHi hold their last value.
REQ-017 SHALL, for writes, drive DataOut=registered data and DataOe=1 during SETUP, STROBE and HOLD; DataOe=0 in IDLE and for all read cycles.
REQ-018 SHALL drive nOE low (reads) or nWE low (writes) only in STROBE; never both low in the same cycle.
REQ-019 SHALL remain in SETUP, STROBE, HOLD for exactly SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES cycles respectively, then HOLD -> IDLE.
REQ-020 SHALL sample DataIn on the last STROBE cycle of a read and present it on RdData with RespValid=1 for exactly the first HOLD cycle; RdData holds its value otherwise.
REQ-021 SHALL not assert RespValid for writes.
REQ-022 SHALL spend at least one cycle in IDLE (nSel high) between consecutive bus cycles; with defaults, accept-to-accept minimum is 9 cycles.
REQ-023 SHALL drive all outputs registered (no combinational path from Req* or DataIn to bus pins), except ReqReady, which is decoded from state.

Reset
REQ-024 SHALL, while Reset is high, force state IDLE, counter 0, nSel=nOE=nWE=nIO=1, DataOe=0, RespValid=0, ReqReady=0, AddrLo/AddrHi/DataOut/RdData=0.
REQ-025 SHALL abort any in-progress cycle immediately on Reset, without completing HOLD or emitting RespValid; ReqReady rises on the first clock edge after Reset falls.

Configuration
REQ-026 SHALL, with macro SWAN_BUS_MASTER_IO_EN defined, honour ReqIo per REQ-016.
REQ-027 SHALL, without SWAN_BUS_MASTER_IO_EN, ignore ReqIo, tie nIO to 1 permanently, and perform every cycle as a memory cycle with otherwise identical timing.

Verification
REQ-028 SHALL cover memory read: accept at cycle N, AddrHi=4'hF, AddrLo=9'h0F0, DataIn=16'hA55A during STROBE -> nSel low N+1..N+8, nOE low N+3..N+6, RespValid=1 at N+7 with RdData=16'hA55A, ReqReady high at N+9.
REQ-029 SHALL cover I/O write (macro defined): AddrHi=4'hE, AddrLo=9'h001, ReqData=16'h0002 -> nIO low and DataOe=1 N+1..N+8, nWE low N+3..N+6, DataOut=16'h0002, no RespValid.
REQ-030 SHALL cover back-to-back: ReqValid held high with two reads -> second accepted at N+9, nSel high exactly one cycle at N+9, no strobe overlap.
REQ-031 SHALL cover Reset asserted mid-STROBE of a write -> nWE, nSel high and DataOe low within the same cycle (asynchronous), no RespValid, IDLE after release.
REQ-032 SHALL cover macro undefined: I/O read request with ReqIo=1 -> nIO stays 1 throughout, nOE timing identical to REQ-028.
REQ-033 SHALL cover parameters SETUP=1, STROBE=1, HOLD=1 -> read completes with RespValid at N+3 and ReqReady at N+4.
